// File: rtl/alm_mul_arbiter.sv
// Round-robin arbiter + two-stage pipeline sharing one combinational ALM multiplier core between NREQ requesters.
// Latency: request handshake at edge k -> rsp_valid high after edge k+1 (no stall); one product per cycle sustained.
// Backpressure: rsp_ready low holds S2, then S1; req_ready drops to all-zero once both stages are full.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        per-requester operand handshake (req_ready one-hot or zero)
//   req_a, req_b               packed operands, requester i at [i*N +: N]
//   mul_a, mul_b, mul_result   registered operands to / combinational product from the core
//   rsp_valid/rsp_ready        tagged response handshake, with rsp_id and rsp_result
//   busy                       either pipeline stage occupied
// Optional feature macro: ALM_ARB_ZERO_SKIP_EN (force product to 0 when either operand is 0).
module alm_mul_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic [N-1:0]        mul_a,
  output logic [N-1:0]        mul_b,
  input  logic [2*N-1:0]      mul_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*N-1:0]      rsp_result,
  output logic                busy
);

  logic            s1_vld;
  logic [N-1:0]    s1_a;
  logic [N-1:0]    s1_b;
  logic [IDW-1:0]  s1_id;
  logic [IDW-1:0]  ptr;

  logic            s2_load;
  logic            s1_free;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  cand;
  logic            hs;
  logic [N-1:0]    a_sel;
  logic [N-1:0]    b_sel;
  logic [2*N-1:0]  s2_dat;

  assign s2_load = s1_vld & (~rsp_valid | rsp_ready);
  assign s1_free = ~s1_vld | s2_load;

  // Scan from ptr upward; IDW-bit addition wraps modulo NREQ since NREQ is a power of two.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + IDW'(k);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign hs = s1_free & gnt_vld;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt_idx] = 1'b1;
  end

  assign a_sel = req_a[gnt_idx*N +: N];
  assign b_sel = req_b[gnt_idx*N +: N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld     <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_id      <= '0;
      ptr        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      if (hs) begin
        s1_vld <= 1'b1;
        s1_a   <= a_sel;
        s1_b   <= b_sel;
        s1_id  <= gnt_idx;
        ptr    <= gnt_idx + IDW'(1);
      end else if (s1_free) begin
        s1_vld <= 1'b0;
      end

      // A pop coinciding with s2_load is absorbed by the reload, so no bubble appears.
      if (s2_load) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= s1_id;
        rsp_result <= s2_dat;
      end else if (rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

`ifdef ALM_ARB_ZERO_SKIP_EN
  // The log-domain core has no leading one to find for a zero operand, so its output is meaningless there.
  logic s1_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_zero <= 1'b0;
    end else if (hs) begin
      s1_zero <= (a_sel == '0) | (b_sel == '0);
    end
  end

  assign s2_dat = s1_zero ? '0 : mul_result;
`else
  assign s2_dat = mul_result;
`endif

  assign mul_a = s1_a;
  assign mul_b = s1_b;
  assign busy  = s1_vld | rsp_valid;

endmodule

// File: tb/tb_alm_mul_arbiter.sv
// Self-checking bench for alm_mul_arbiter: directed scenarios plus random traffic against a queue-based model.
// Latency: n/a (bench).
// Backpressure: rsp_ready driven directly, including long stalls.
module tb_alm_mul_arbiter;
  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam logic [2*N-1:0] ZERO_JUNK = 32'hA5A5_5A5A;
`ifdef ALM_ARB_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [N-1:0]      mul_a;
  logic [N-1:0]      mul_b;
  logic [2*N-1:0]    mul_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*N-1:0]    rsp_result;
  logic              busy;

  alm_mul_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in core: exact product, but garbage when an operand is zero (as a log-domain core would give).
  function automatic logic [2*N-1:0] core_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] wa, wb;
    if (a == '0 || b == '0) return ZERO_JUNK;
    wa = {{N{1'b0}}, a};
    wb = {{N{1'b0}}, b};
    return wa * wb;
  endfunction

  assign mul_result = core_mul(mul_a, mul_b);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: in-order list of accepted operations; each is either waiting behind the core or presented as a response.
  typedef struct {
    logic [IDW-1:0] id;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] res;
    bit             shown;
  } op_t;

  op_t pipe[$];
  int  ptr_m      = 0;
  int  last_grant = -1;
  int  n_pop      = 0;

  // Checks outputs mid-cycle against the model, then advances the model across one rising edge.
  task automatic step();
    bit rv, waiting, pop, mv, fr;
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [N-1:0] ga, gb;
    op_t e;
    @(negedge clk);
    rv      = (pipe.size() > 0) && pipe[0].shown;
    waiting = (pipe.size() > 0) && !pipe[pipe.size()-1].shown;
    pop     = rv && rsp_ready;
    mv      = waiting && (!rv || pop);
    fr      = !waiting || mv;
    g = -1;
    if (fr) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(rv));
    chk("busy", 64'(busy), 64'(pipe.size() > 0));
    if (rv) begin
      chk("rsp_id", 64'(rsp_id), 64'(pipe[0].id));
      chk("rsp_result", 64'(rsp_result), 64'(pipe[0].res));
    end
    if (waiting) chk("mul_ops", 64'({mul_a, mul_b}), 64'({pipe[pipe.size()-1].a, pipe[pipe.size()-1].b}));
    ga = '0;
    gb = '0;
    if (g >= 0) begin
      ga = req_a[g*N +: N];
      gb = req_b[g*N +: N];
    end
    last_grant = g;
    @(posedge clk);
    if (pop) begin
      void'(pipe.pop_front());
      n_pop++;
    end
    if (mv) begin
      e = pipe.pop_back();
      e.shown = 1'b1;
      pipe.push_back(e);
    end
    if (g >= 0) begin
      e.id    = IDW'(g);
      e.a     = ga;
      e.b     = gb;
      e.res   = (ZS && (ga == '0 || gb == '0)) ? '0 : core_mul(ga, gb);
      e.shown = 1'b0;
      pipe.push_back(e);
      ptr_m = (g + 1) % NREQ;
    end
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"}, 64'(req_ready), 64'd0);
    chk({tag, "_mul"}, 64'({mul_a, mul_b}), 64'd0);
    chk({tag, "_rsp"}, 64'({rsp_valid, rsp_id, rsp_result}), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom);
      req_b[i*N +: N] = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom);
    end
  endtask

  int acc;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request from requester 2: 4 * 8.
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_a[2*N +: N] = 16'd4;
    req_b[2*N +: N] = 16'd8;
    #1;
    chk("single_rdy", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;
    step();
    chk("single_vld", 64'(rsp_valid), 64'd1);
    chk("single_id", 64'(rsp_id), 64'd2);
    chk("single_res", 64'(rsp_result), 64'd32);
    step();

    // Fairness: all requesting; pointer sits at 3 after the single request.
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      randomize_ops();
      step();
      chk("fair_gnt", 64'(last_grant), 64'((3 + i) % NREQ));
    end
    req_valid = '0;
    repeat (3) step();

    // Backpressure: requester 0 streams while the response side stalls.
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      randomize_ops();
      step();
      if (last_grant >= 0) acc++;
    end
    chk("bp_accepts", 64'(acc), 64'd2);
    chk("bp_rdy_low", 64'(req_ready), 64'd0);
    req_valid = '0;
    rsp_ready = 1'b1;
    n_pop = 0;
    repeat (4) step();
    chk("bp_drained", 64'(n_pop), 64'd2);

    // Pointer wrap: 3 alone, then 0 and 3 together -> 0 first.
    req_valid = 4'b1000;
    step();
    req_valid = 4'b1001;
    #1;
    chk("wrap_rdy", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    repeat (3) step();

    // Zero operand.
    req_valid = 4'b0010;
    req_a[1*N +: N] = 16'd0;
    req_b[1*N +: N] = 16'd1234;
    step();
    req_valid = '0;
    step();
    chk("zero_res", 64'(rsp_result), ZS ? 64'd0 : 64'(ZERO_JUNK));
    step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      randomize_ops();
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) step();

    // Reset with both stages full.
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    randomize_ops();
    step();
    step();
    chk("pre_rst_busy", 64'({rsp_valid, busy}), 64'b11);
    req_valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    pipe.delete();
    ptr_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    step();
    chk("no_stale", 64'(rsp_valid), 64'd0);
    req_valid = 4'b1011;
    #1;
    chk("post_rst_gnt", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
